or_reduce_sched: RTL and testbench

//  Shares one fixed-latency square/XOR/OR-reduce datapath (the flopped OR_16b pipe) among NUM_REQ requesters.

---
 rtl/or_reduce_pkg.sv | 21 ++
 rtl/or_reduce_resp_fifo.sv | 66 ++++++
 rtl/or_reduce_sched.sv | 166 ++++++++++++++++
 tb/tb_or_reduce_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/or_reduce_pkg.sv
// Shared types and defaults for the OR-reduce scheduler: requester id width, response record
// and a ring-index helper usable for non-power-of-2 sizes.
package or_reduce_pkg;

    localparam int unsigned NUM_REQ_DEFAULT    = 4;
    localparam int unsigned BITWIDTH_DEFAULT   = 16;
    localparam int unsigned DP_LATENCY_DEFAULT = 4;
    localparam int unsigned RESP_DEPTH_DEFAULT = 8;

    localparam int unsigned ID_W = $clog2(NUM_REQ_DEFAULT);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            result;
    } resp_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/or_reduce_resp_fifo.sv
// Synchronous response FIFO of resp_t. Head entry is read straight from the storage registers;
// pointers wrap at Depth so any depth works.
module or_reduce_resp_fifo
    import or_reduce_pkg::*;
#(
    parameter int unsigned Depth = RESP_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  resp_t                      push_data,
    input  logic                       pop,
    output resp_t                      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    resp_t           mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full   = (count_q == CntW'(Depth));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A full FIFO may only accept a push when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/or_reduce_sched.sv
// Round-robin scheduler sharing one fixed-latency OR-reduce datapath among NUM_REQ requesters,
// with id tagging, credit flow control and an in-order response FIFO.
module or_reduce_sched
    import or_reduce_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int unsigned BITWIDTH   = BITWIDTH_DEFAULT,
    parameter int unsigned DP_LATENCY = DP_LATENCY_DEFAULT,
    parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0] req_data,
    output logic                        dp_valid,
    output logic [BITWIDTH-1:0]         dp_a,
    input  logic                        dp_result,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  resp_id,
    output logic                        resp_result
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned CredW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);

    logic [IdW-1:0]      rr_ptr_q;
    logic [IdW-1:0]      grant_id;
    logic                grant_any;
    logic                can_issue;
    logic                handshake;
    logic [CredW-1:0]    credits_q;

    logic                dp_valid_q;
    logic [BITWIDTH-1:0] dp_a_q;
    logic [IdW-1:0]      issue_id_q;

    logic [DP_LATENCY-1:0] tag_valid_q;
    logic [IdW-1:0]        tag_id_q [DP_LATENCY];

    resp_t           push_data;
    resp_t           head;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    // ---------------- arbitration ----------------
    always_comb begin
        int unsigned idx;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[IdW'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = IdW'(idx);
            end
        end
    end

    // Ready is masked during reset so no request is consumed while state is being cleared.
    assign can_issue = (credits_q != '0) && !rst;

    always_comb begin
        req_ready = '0;
        if (can_issue && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);

    // ---------------- issue register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            dp_valid_q <= 1'b0;
            dp_a_q     <= '0;
            issue_id_q <= '0;
        end else begin
            dp_valid_q <= handshake;
            if (handshake) begin
                dp_a_q     <= req_data[32'(grant_id)*BITWIDTH +: BITWIDTH];
                issue_id_q <= grant_id;
                rr_ptr_q   <= IdW'(wrap_inc(32'(grant_id), NUM_REQ));
            end
        end
    end

    assign dp_valid = dp_valid_q;
    assign dp_a     = dp_a_q;

    // ---------------- tag pipe ----------------
    // Mirrors the datapath latency so the exiting tag lines up with dp_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_q <= '0;
            for (int unsigned i = 0; i < DP_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= dp_valid_q;
            tag_id_q[0]    <= issue_id_q;
            for (int unsigned i = 1; i < DP_LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
        end
    end

    assign push             = tag_valid_q[DP_LATENCY-1];
    assign push_data.id     = tag_id_q[DP_LATENCY-1];
    assign push_data.result = dp_result;

    // ---------------- credits ----------------
    assign pop = resp_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CredW'(RESP_DEPTH);
        end else begin
            case ({handshake, pop})
                2'b10:   credits_q <= credits_q - CredW'(1);
                2'b01:   credits_q <= credits_q + CredW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    // ---------------- response FIFO ----------------
    or_reduce_resp_fifo #(
        .Depth (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign resp_valid  = !fifo_empty;
    assign resp_id     = head.id;
    assign resp_result = head.result;

    // Every credit is either free, riding the issue/tag pipe, or parked in the FIFO.
    a_credit_conservation: assert property (@(posedge clk) disable iff (rst)
        32'(credits_q) + $countones({tag_valid_q, dp_valid_q}) + 32'(fifo_count) == RESP_DEPTH);
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        32'(credits_q) <= RESP_DEPTH);
    a_push_not_full: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));
    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_or_reduce_sched.sv
// Directed bench for or_reduce_sched: models the 4-cycle OR-reduce datapath and checks every
// cycle against a cycle-level reference of arbitration, credits and response ordering.
module tb_or_reduce_sched;
    import or_reduce_pkg::*;

    localparam int unsigned NR    = 4;
    localparam int unsigned BW    = 16;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*BW-1:0] req_data;
    logic             dp_valid;
    logic [BW-1:0]    dp_a;
    logic             dp_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic             resp_result;

    always #5 clk = ~clk;

    or_reduce_sched #(
        .NUM_REQ    (NR),
        .BITWIDTH   (BW),
        .DP_LATENCY (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .dp_valid    (dp_valid),
        .dp_a        (dp_a),
        .dp_result   (dp_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    // Square, fold the 32-bit square by XOR of its halves, then OR-reduce.
    function automatic logic dp_ref(input logic [BW-1:0] a);
        logic [31:0] sq;
        sq = 32'(a) * 32'(a);
        return |(sq[31:16] ^ sq[15:0]);
    endfunction

    // Datapath stand-in: four flop stages, never reset.
    logic [LAT-1:0] dp_pipe;
    always @(posedge clk) dp_pipe <= {dp_pipe[LAT-2:0], (dp_valid === 1'b1) ? dp_ref(dp_a) : 1'b0};
    assign dp_result = dp_pipe[LAT-1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int   id;
        logic res;
        int   due;
    } exp_t;

    exp_t          q[$];
    int            credits_m;
    int            ptr_m;
    logic          dpv_m;
    logic [BW-1:0] dpa_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [BW-1:0] d);
        req_data[i*BW +: BW] = d;
    endtask

    // One clock cycle: check outputs against the reference, then advance both.
    task automatic step();
        logic [NR-1:0] exp_ready;
        int            g;
        logic          rv_m;
        logic          pop_m;
        exp_t          e;
        #1;
        exp_ready = '0;
        g         = -1;
        if (!rst && credits_m > 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (ptr_m + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("dp_valid", 32'(dp_valid), 32'(dpv_m));
        check("dp_a", 32'(dp_a), 32'(dpa_m));
        rv_m = (q.size() > 0) && (q[0].due <= cyc);
        check("resp_valid", 32'(resp_valid), 32'(rv_m));
        if (rv_m) begin
            check("resp_id", 32'(resp_id), 32'(q[0].id));
            check("resp_result", 32'(resp_result), 32'(q[0].res));
        end
        pop_m = rv_m && resp_ready;
        if (rst) begin
            q.delete();
            credits_m = DEPTH;
            ptr_m     = 0;
            dpv_m     = 1'b0;
            dpa_m     = '0;
        end else begin
            if (pop_m) begin
                void'(q.pop_front());
                credits_m++;
            end
            dpv_m = (g >= 0);
            if (g >= 0) begin
                dpa_m = req_data[g*BW +: BW];
                e.id  = g;
                e.res = dp_ref(dpa_m);
                e.due = cyc + LAT + 2;
                q.push_back(e);
                ptr_m = (g + 1) % NR;
                credits_m--;
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        req_data   = '0;
        credits_m  = DEPTH;
        ptr_m      = 0;
        dpv_m      = 1'b0;
        dpa_m      = '0;
        @(posedge clk);
        #2;

        // Reset held with every requester asking: nothing may be granted.
        repeat (3) step();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("reset_credits", 32'(dut.credits_q), 32'(DEPTH));
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_resp_result", 32'(resp_result), 32'd0);
        check("reset_dp_a", 32'(dp_a), 32'd0);

        // Single op from requester 2: 3*3=9 -> result 1, response 6 cycles after handshake.
        set_req(2, 16'h0003);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (5) step();
        #1;
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_id", 32'(resp_id), 32'd2);
        check("single_result", 32'(resp_result), 32'd1);
        step();
        step();

        // Zero operand gives result 0.
        set_req(2, 16'h0000);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (5) step();
        #1;
        check("zero_valid", 32'(resp_valid), 32'd1);
        check("zero_id", 32'(resp_id), 32'd2);
        check("zero_result", 32'(resp_result), 32'd0);
        step();
        step();

        // Fairness: all requesters valid, consumer always ready -> one grant per cycle in rotation.
        set_req(0, 16'h0000);
        set_req(1, 16'h0003);
        set_req(2, 16'h0100);
        set_req(3, 16'hFFFF);
        req_valid = '1;
        repeat (16) step();
        req_valid = '0;
        repeat (10) step();
        #1;
        check("fair_drained_credits", 32'(dut.credits_q), 32'(DEPTH));

        // Backpressure: consumer stalled -> exactly DEPTH grants, then ready stays low.
        resp_ready = 1'b0;
        req_valid  = '1;
        repeat (14) step();
        #1;
        check("bp_credits_zero", 32'(dut.credits_q), 32'd0);
        check("bp_fifo_full", 32'(dut.u_fifo.count_q), 32'(DEPTH));
        check("bp_no_ready", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        step();
        step();

        // Pop and issue in the same cycle from the zero-credit edge; FIFO pushes while near full.
        resp_ready = 1'b1;
        repeat (16) step();
        req_valid = '0;
        repeat (12) step();
        #1;
        check("sim_drained_credits", 32'(dut.credits_q), 32'(DEPTH));

        // Reset with three ops in flight: their results must never surface.
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();

        // First op after reset returns normally: 0x8000^2 = 0x40000000 -> result 1.
        set_req(1, 16'h8000);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (5) step();
        #1;
        check("post_reset_valid", 32'(resp_valid), 32'd1);
        check("post_reset_id", 32'(resp_id), 32'd1);
        check("post_reset_result", 32'(resp_result), 32'd1);
        step();
        step();
        #1;
        check("final_credits", 32'(dut.credits_q), 32'(DEPTH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
